// File: rtl/mig_mem_arbiter_if.sv
// mig_mem_arbiter_if
// Bundles the three requester ports (instruction fetch i_*, load/store d_*,
// loader/debug x_*) and the single-port RAM port (mem_*) of the MigU memory
// arbiter.
//   slave  : arbiter view (takes requests and mem_rdata, drives grants,
//            read responses and the RAM command)
//   master : environment view (requesters plus RAM model)
// All address fields are word addresses [ADDR_WIDTH-1:2].
interface mig_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);

  // instruction-fetch port (read only)
  logic                    i_req;
  logic [ADDR_WIDTH-1:2]   i_addr;
  logic                    i_gnt;
  logic                    i_rvalid;
  logic [DATA_WIDTH-1:0]   i_rdata;

  // load/store port
  logic                    d_req;
  logic                    d_we;
  logic [ADDR_WIDTH-1:2]   d_addr;
  logic [DATA_WIDTH-1:0]   d_wdata;
  logic [DATA_WIDTH/8-1:0] d_wstrb;
  logic                    d_gnt;
  logic                    d_rvalid;
  logic [DATA_WIDTH-1:0]   d_rdata;

  // loader/debug port; x_lock asks to keep ownership across cycles
  logic                    x_req;
  logic                    x_lock;
  logic                    x_we;
  logic [ADDR_WIDTH-1:2]   x_addr;
  logic [DATA_WIDTH-1:0]   x_wdata;
  logic [DATA_WIDTH/8-1:0] x_wstrb;
  logic                    x_gnt;
  logic                    x_rvalid;
  logic [DATA_WIDTH-1:0]   x_rdata;

  // RAM port
  logic                    mem_en;
  logic [DATA_WIDTH/8-1:0] mem_we;
  logic [ADDR_WIDTH-1:2]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    output d_gnt, d_rvalid, d_rdata,
    input  x_req, x_lock, x_we, x_addr, x_wdata, x_wstrb,
    output x_gnt, x_rvalid, x_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  d_gnt, d_rvalid, d_rdata,
    output x_req, x_lock, x_we, x_addr, x_wdata, x_wstrb,
    input  x_gnt, x_rvalid, x_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mig_mem_arbiter.sv
// mig_mem_arbiter
// Shares one synchronous single-port word RAM between the MigU instruction
// fetch port (i), load/store port (d) and loader/debug port (x).  At most one
// access is granted per cycle; read data returns to the owner one cycle
// later.  x has fixed priority and may lock the RAM for bulk loads; i and d
// alternate round-robin when both are pending.
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   bus          mig_mem_arbiter_if.slave (requesters + RAM)
//   conflict_cnt saturating count of cycles with two or more requesters
module mig_mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  mig_mem_arbiter_if.slave    bus,
  output logic [15:0]         conflict_cnt
);

  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic {
    ARB,
    LOCK
  } state_t;

  typedef enum logic [1:0] {
    OWN_I,
    OWN_D,
    OWN_X
  } owner_t;

  state_t                state;
  state_t                state_next;
  logic                  last_di;
  logic                  rd_pend;
  owner_t                owner;
  owner_t                win_owner;
  logic                  win_read;
  logic                  gnt_i;
  logic                  gnt_d;
  logic                  gnt_x;
  logic                  any_gnt;
  logic                  multi_req;
  logic [SW-1:0]         win_we;
  logic [ADDR_WIDTH-1:2] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

  // Grant selection and next state.  While locked, only x may be granted;
  // the cycle x_lock drops, the normal ARB rules apply again immediately.
  // Reset suppresses every grant.
  always_comb begin
    gnt_i      = 1'b0;
    gnt_d      = 1'b0;
    gnt_x      = 1'b0;
    state_next = state;
    if (!rst) begin
      if (state == LOCK && bus.x_lock) begin
        gnt_x = bus.x_req;
      end else begin
        if (bus.x_req) begin
          gnt_x = 1'b1;
        end else if (bus.i_req && bus.d_req) begin
          // last_di = 1 means d won last, so i gets this tie
          if (last_di) begin
            gnt_i = 1'b1;
          end else begin
            gnt_d = 1'b1;
          end
        end else if (bus.i_req) begin
          gnt_i = 1'b1;
        end else if (bus.d_req) begin
          gnt_d = 1'b1;
        end
        state_next = (gnt_x && bus.x_lock) ? LOCK : ARB;
      end
    end
  end

  // RAM command from the winner; idle bus is driven to zero.  A write with
  // an all-zero strobe is still an access, but it is not a read.
  always_comb begin
    win_we    = '0;
    win_addr  = '0;
    win_wdata = '0;
    win_read  = 1'b0;
    win_owner = OWN_I;
    if (gnt_x) begin
      win_we    = bus.x_we ? bus.x_wstrb : '0;
      win_addr  = bus.x_addr;
      win_wdata = bus.x_wdata;
      win_read  = !bus.x_we;
      win_owner = OWN_X;
    end else if (gnt_d) begin
      win_we    = bus.d_we ? bus.d_wstrb : '0;
      win_addr  = bus.d_addr;
      win_wdata = bus.d_wdata;
      win_read  = !bus.d_we;
      win_owner = OWN_D;
    end else if (gnt_i) begin
      win_addr  = bus.i_addr;
      win_read  = 1'b1;
      win_owner = OWN_I;
    end
  end

  assign any_gnt   = gnt_i | gnt_d | gnt_x;
  assign multi_req = (bus.i_req & bus.d_req) | (bus.i_req & bus.x_req) |
                     (bus.d_req & bus.x_req);

  // State, round-robin history, pending read owner and conflict counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARB;
      last_di      <= 1'b1;
      rd_pend      <= 1'b0;
      owner        <= OWN_I;
      conflict_cnt <= 16'd0;
    end else begin
      state <= state_next;
      if (gnt_i) begin
        last_di <= 1'b0;
      end else if (gnt_d) begin
        last_di <= 1'b1;
      end
      rd_pend <= any_gnt && win_read;
      if (any_gnt) begin
        owner <= win_owner;
      end
      if (multi_req && conflict_cnt != 16'hFFFF) begin
        conflict_cnt <= conflict_cnt + 16'd1;
      end
    end
  end

  assign bus.i_gnt     = gnt_i;
  assign bus.d_gnt     = gnt_d;
  assign bus.x_gnt     = gnt_x;
  assign bus.mem_en    = any_gnt;
  assign bus.mem_we    = win_we;
  assign bus.mem_addr  = win_addr;
  assign bus.mem_wdata = win_wdata;

  // A read pending across a reset cycle is dropped, so the response is
  // masked by rst as well as by the recorded owner.
  assign bus.i_rvalid = rd_pend && (owner == OWN_I) && !rst;
  assign bus.d_rvalid = rd_pend && (owner == OWN_D) && !rst;
  assign bus.x_rvalid = rd_pend && (owner == OWN_X) && !rst;
  assign bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : '0;
  assign bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : '0;
  assign bus.x_rdata  = bus.x_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mig_mem_arbiter.sv
// tb_mig_mem_arbiter
// Directed bench for mig_mem_arbiter: a 256-word RAM model reloaded on reset,
// a table of single-cycle vectors for arbitration/lock/response behaviour,
// and hand-written sequences for reset, masked writes, locked bulk loads and
// counter saturation.
module tb_mig_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] conflict_cnt;
  int          checks;
  int          errors;

  mig_mem_arbiter_if bus ();

  mig_mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: byte-masked writes, registered read data, preload on reset
  logic [31:0] ram [0:255];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) ram[k] <= 32'h0;
      ram[8'h10]    <= 32'h0000_0013;
      ram[8'h08]    <= 32'h1111_2222;
      ram[8'h30]    <= 32'h3333_4444;
      bus.mem_rdata <= 32'h0;
    end else if (bus.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) ram[bus.mem_addr[9:2]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
      bus.mem_rdata <= ram[bus.mem_addr[9:2]];
    end
  end

  typedef struct packed {
    logic       i_req;
    logic       d_req;
    logic       x_req;
    logic       x_lock;
    logic       d_we;
    logic [2:0] exp_gnt;
    logic [2:0] exp_rv;
  } vec_t;

  vec_t vecs [14];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.i_req   = v.i_req;
    bus.i_addr  = 14'h10;
    bus.d_req   = v.d_req;
    bus.d_we    = v.d_we;
    bus.d_addr  = 14'h08;
    bus.d_wdata = 32'hCAFE_F00D;
    bus.d_wstrb = 4'b0000;
    bus.x_req   = v.x_req;
    bus.x_lock  = v.x_lock;
    bus.x_we    = 1'b0;
    bus.x_addr  = 14'h30;
    bus.x_wdata = 32'h0;
    bus.x_wstrb = 4'b0000;
  endtask

  task automatic idleInputs();
    applyStimulus('0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    idleInputs();
    nextCycle();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] expAddr(input logic [2:0] g);
    case (g)
      3'b001:  return 32'h10;
      3'b010:  return 32'h08;
      3'b100:  return 32'h30;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    checks = 0;
    errors = 0;

    // {i_req, d_req, x_req, x_lock, d_we, exp_gnt{x,d,i}, exp_rv{x,d,i}}
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 3'b000}; // i alone
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 3'b001}; // tie -> d
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 3'b010}; // tie -> i
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 3'b001}; // d alone
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 3'b010}; // tie -> i
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b100, 3'b001}; // x priority
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 3'b100}; // x leaves last_di
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b100, 3'b010}; // lock taken
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b100, 3'b100}; // locked
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b100}; // locked, x idle
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 3'b000}; // unlock same cycle
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b001};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 3'b000}; // write, strobe 0
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000}; // no rvalid

    // Reset cycle with all requesters active: nothing granted or counted
    rst = 1'b1;
    applyStimulus('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000});
    @(negedge clk);
    checkOutput("rst gnt", 32'({bus.x_gnt, bus.d_gnt, bus.i_gnt}), 32'h0);
    checkOutput("rst mem_en", 32'(bus.mem_en), 32'h0);
    checkOutput("rst mem_we", 32'(bus.mem_we), 32'h0);
    nextCycle();
    rst = 1'b0;
    idleInputs();
    @(negedge clk);
    checkOutput("rst rvalid", 32'({bus.x_rvalid, bus.d_rvalid, bus.i_rvalid}), 32'h0);
    checkOutput("rst conflict_cnt", 32'(conflict_cnt), 32'h0);
    doReset();

    // Table of single-cycle vectors
    for (int k = 0; k < 14; k++) begin
      applyStimulus(vecs[k]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d gnt", k), 32'({bus.x_gnt, bus.d_gnt, bus.i_gnt}), 32'(vecs[k].exp_gnt));
      checkOutput($sformatf("vec%0d rvalid", k), 32'({bus.x_rvalid, bus.d_rvalid, bus.i_rvalid}), 32'(vecs[k].exp_rv));
      checkOutput($sformatf("vec%0d mem_en", k), 32'(bus.mem_en), 32'(|vecs[k].exp_gnt));
      checkOutput($sformatf("vec%0d mem_we", k), 32'(bus.mem_we), 32'h0);
      checkOutput($sformatf("vec%0d mem_addr", k), 32'(bus.mem_addr), expAddr(vecs[k].exp_gnt));
      checkOutput($sformatf("vec%0d i_rdata", k), bus.i_rdata, vecs[k].exp_rv[0] ? 32'h0000_0013 : 32'h0);
      checkOutput($sformatf("vec%0d d_rdata", k), bus.d_rdata, vecs[k].exp_rv[1] ? 32'h1111_2222 : 32'h0);
      checkOutput($sformatf("vec%0d x_rdata", k), bus.x_rdata, vecs[k].exp_rv[2] ? 32'h3333_4444 : 32'h0);
      nextCycle();
    end
    checkOutput("table conflict_cnt", 32'(conflict_cnt), 32'd8);

    // Fetch alone, data one cycle later
    doReset();
    applyStimulus('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000});
    @(negedge clk);
    checkOutput("fetch i_gnt", 32'(bus.i_gnt), 32'h1);
    nextCycle();
    idleInputs();
    @(negedge clk);
    checkOutput("fetch i_rvalid", 32'(bus.i_rvalid), 32'h1);
    checkOutput("fetch i_rdata", bus.i_rdata, 32'h0000_0013);

    // i and d held together: i,d,i,d and four conflicts
    doReset();
    applyStimulus('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rr%0d gnt", k), 32'({bus.d_gnt, bus.i_gnt}), (k % 2 == 0) ? 32'h1 : 32'h2);
      nextCycle();
    end
    idleInputs();
    @(negedge clk);
    checkOutput("rr conflict_cnt", 32'(conflict_cnt), 32'd4);

    // Byte-masked write then read back over a zero word
    doReset();
    idleInputs();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 14'h20;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_wstrb = 4'b0011;
    @(negedge clk);
    checkOutput("wr d_gnt", 32'(bus.d_gnt), 32'h1);
    checkOutput("wr mem_we", 32'(bus.mem_we), 32'h3);
    checkOutput("wr mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    nextCycle();
    bus.d_we = 1'b0;
    @(negedge clk);
    checkOutput("rd d_gnt", 32'(bus.d_gnt), 32'h1);
    checkOutput("wr no rvalid", 32'(bus.d_rvalid), 32'h0);
    nextCycle();
    idleInputs();
    @(negedge clk);
    checkOutput("rd d_rvalid", 32'(bus.d_rvalid), 32'h1);
    checkOutput("rd d_rdata", bus.d_rdata, 32'h0000_BEEF);

    // Locked bulk load with i starving, released on cycle 9
    doReset();
    idleInputs();
    bus.i_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.x_req = 1'b1; bus.x_lock = 1'b1; bus.x_we = 1'b1;
      bus.x_addr = 14'(8'h40 + k); bus.x_wdata = 32'(k); bus.x_wstrb = 4'hF;
      @(negedge clk);
      checkOutput($sformatf("lock%0d x_gnt", k), 32'(bus.x_gnt), 32'h1);
      checkOutput($sformatf("lock%0d i_gnt", k), 32'(bus.i_gnt), 32'h0);
      nextCycle();
    end
    bus.x_req = 1'b0; bus.x_lock = 1'b0;
    @(negedge clk);
    checkOutput("unlock i_gnt", 32'(bus.i_gnt), 32'h1);
    checkOutput("unlock x_gnt", 32'(bus.x_gnt), 32'h0);
    nextCycle();
    checkOutput("lock ram word", ram[8'h47], 32'd7);

    // Reset the cycle after a d read grant: response dropped
    doReset();
    idleInputs();
    bus.d_req = 1'b1; bus.d_addr = 14'h08;
    @(negedge clk);
    checkOutput("pre-rst d_gnt", 32'(bus.d_gnt), 32'h1);
    nextCycle();
    rst = 1'b1;
    bus.i_req = 1'b1;
    @(negedge clk);
    checkOutput("rst d_rvalid", 32'(bus.d_rvalid), 32'h0);
    checkOutput("rst d_rdata", bus.d_rdata, 32'h0);
    checkOutput("rst gnts held", 32'({bus.x_gnt, bus.d_gnt, bus.i_gnt}), 32'h0);
    checkOutput("rst mem_en held", 32'(bus.mem_en), 32'h0);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post-rst tie to i", 32'({bus.d_gnt, bus.i_gnt}), 32'h1);
    checkOutput("post-rst conflict_cnt", 32'(conflict_cnt), 32'h0);

    // Three-way contention until the counter saturates
    doReset();
    applyStimulus('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000});
    repeat (65534) nextCycle();
    checkOutput("sat FFFE", 32'(conflict_cnt), 32'hFFFE);
    nextCycle();
    checkOutput("sat FFFF", 32'(conflict_cnt), 32'hFFFF);
    repeat (70000 - 65535) nextCycle();
    checkOutput("sat hold", 32'(conflict_cnt), 32'hFFFF);
    idleInputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
